// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, reset PC, instruction field positions, fetch FSM states.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;

  // Instruction word fields, also used by decode.
  localparam int unsigned TWO_WORD_BIT = 15;
  localparam int unsigned SRC_HI = 10;
  localparam int unsigned SRC_LO = 8;
  localparam int unsigned DST_HI = 7;
  localparam int unsigned DST_LO = 5;

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, hold, or clear valid; async active-high reset.
module if_id_reg #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear_valid,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] pc
);

  // Clear-valid wins over load; otherwise everything holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= '0;
      imm   <= '0;
      pc    <= '0;
    end else if (clear_valid) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      imm   <= imm_in;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, one/two-word assembly FSM, stall and redirect handling.
module fetch_stage #(
  parameter int unsigned       DATA_W   = cpu_pkg::DATA_W,
  parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_imm,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [2:0]        src_addr,
  output logic [2:0]        dst_addr
);

  cpu_pkg::fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic              ld;
  logic              clr;
  logic [DATA_W-1:0] ld_instr;
  logic [DATA_W-1:0] ld_imm;
  logic [ADDR_W-1:0] ld_pc;

  // State, PC and holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= cpu_pkg::S_OP;
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  // Next-state and IF/ID control; redirect overrides stall in either state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    ld           = 1'b0;
    clr          = 1'b0;
    ld_instr     = imem_rdata;
    ld_imm       = '0;
    ld_pc        = pc_q;
    if (branch_taken) begin
      state_d      = cpu_pkg::S_OP;
      pc_d         = branch_target;
      hold_instr_d = '0;
      hold_pc_d    = '0;
      clr          = 1'b1;
    end else if (!stall) begin
      pc_d = pc_q + ADDR_W'(1);
      case (state_q)
        cpu_pkg::S_OP: begin
          if (imem_rdata[cpu_pkg::TWO_WORD_BIT]) begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_q;
            clr          = 1'b1;
            state_d      = cpu_pkg::S_IMM;
          end else begin
            ld = 1'b1;
          end
        end
        cpu_pkg::S_IMM: begin
          ld       = 1'b1;
          ld_instr = hold_instr_q;
          ld_imm   = imem_rdata;
          ld_pc    = hold_pc_q;
          state_d  = cpu_pkg::S_OP;
        end
        default: state_d = cpu_pkg::S_OP;
      endcase
    end
  end

  if_id_reg #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .load       (ld),
    .clear_valid(clr),
    .instr_in   (ld_instr),
    .imm_in     (ld_imm),
    .pc_in      (ld_pc),
    .valid      (if_id_valid),
    .instr      (if_id_instr),
    .imm        (if_id_imm),
    .pc         (if_id_pc)
  );

  assign imem_addr = pc_q;
  assign src_addr  = if_id_instr[cpu_pkg::SRC_HI:cpu_pkg::SRC_LO];
  assign dst_addr  = if_id_instr[cpu_pkg::DST_HI:cpu_pkg::DST_LO];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an asynchronous-read instruction memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_imm;
  logic [15:0] if_id_pc;
  logic [2:0]  src_addr;
  logic [2:0]  dst_addr;

  logic [15:0] mem [0:65535];
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .if_id_valid  (if_id_valid),
    .if_id_instr  (if_id_instr),
    .if_id_imm    (if_id_imm),
    .if_id_pc     (if_id_pc),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_instr(input string tag, input logic [15:0] instr, input logic [15:0] imm,
                           input logic [15:0] pc);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'd1);
    chk({tag, "_instr"}, 32'(if_id_instr), 32'(instr));
    chk({tag, "_imm"},   32'(if_id_imm),   32'(imm));
    chk({tag, "_pc"},    32'(if_id_pc),    32'(pc));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[0]     = 16'h0120;
    mem[1]     = 16'h0300;
    mem[2]     = 16'h0460;
    mem[3]     = 16'h0700;
    mem[4]     = 16'h8A40;
    mem[5]     = 16'h1234;
    mem[6]     = 16'h8B00;
    mem[7]     = 16'h5555;
    mem[8]     = 16'h0123;
    mem[9]     = 16'h9C00;
    mem[10]    = 16'hBEEF;
    mem[16'h0040] = 16'h0240;
    mem[16'h0050] = 16'h0100;
    mem[16'h0051] = 16'h8800;
    mem[16'h0052] = 16'h1111;
    mem[16'hFFFF] = 16'h8000;

    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    step(); step();
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", 32'(if_id_instr), 32'd0);
    chk("rst_imm",   32'(if_id_imm),   32'd0);
    chk("rst_pc",    32'(if_id_pc),    32'd0);
    chk("rst_addr",  32'(imem_addr),   32'd0);

    // First single-word fetch after release.
    reset = 1'b0;
    step();
    chk_instr("sw0", 16'h0120, 16'h0000, 16'h0000);
    chk("sw0_src",  32'(src_addr),  32'd1);
    chk("sw0_dst",  32'(dst_addr),  32'd1);
    chk("sw0_addr", 32'(imem_addr), 32'd1);
    step(); chk_instr("sw1", 16'h0300, 16'h0000, 16'h0001);
    step(); chk_instr("sw2", 16'h0460, 16'h0000, 16'h0002);
    step(); chk_instr("sw3", 16'h0700, 16'h0000, 16'h0003);
    chk("sw3_addr", 32'(imem_addr), 32'd4);

    // Two-word instruction at PC=4: bubble then complete.
    step();
    chk("tw_bubble", 32'(if_id_valid), 32'd0);
    chk("tw_baddr",  32'(imem_addr),   32'd5);
    step();
    chk_instr("tw", 16'h8A40, 16'h1234, 16'h0004);
    chk("tw_src",  32'(src_addr),  32'd2);
    chk("tw_dst",  32'(dst_addr),  32'd2);
    chk("tw_addr", 32'(imem_addr), 32'd6);

    // Stall three cycles while in S_IMM.
    step();
    chk("st_enter", 32'(imem_addr), 32'd7);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("st_addr",  32'(imem_addr),   32'd7);
      chk("st_valid", 32'(if_id_valid), 32'd0);
    end
    stall = 1'b0;
    step();
    chk_instr("st_done", 16'h8B00, 16'h5555, 16'h0006);
    chk("st_daddr", 32'(imem_addr), 32'd8);

    // Stall with a valid instruction held in IF/ID.
    stall = 1'b1;
    step();
    chk("sv_addr", 32'(imem_addr), 32'd8);
    chk_instr("sv_hold", 16'h8B00, 16'h5555, 16'h0006);
    stall = 1'b0;
    step();
    chk_instr("sv_next", 16'h0123, 16'h0000, 16'h0008);

    // Redirect with stall while in S_IMM abandons the held opcode.
    step();
    chk("br_enter", 32'(imem_addr),   32'd10);
    chk("br_evld",  32'(if_id_valid), 32'd0);
    branch_taken = 1'b1; branch_target = 16'h0040; stall = 1'b1;
    step();
    chk("br_addr",  32'(imem_addr),   32'h0040);
    chk("br_valid", 32'(if_id_valid), 32'd0);
    branch_taken = 1'b0; stall = 1'b0;
    step();
    chk_instr("br_tgt", 16'h0240, 16'h0000, 16'h0040);
    chk("br_taddr", 32'(imem_addr), 32'h0041);

    // PC wrap between opcode and immediate words.
    mem[0] = 16'h0007;
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    step();
    branch_taken = 1'b0;
    chk("wr_addr", 32'(imem_addr), 32'hFFFF);
    step();
    chk("wr_bubble", 32'(if_id_valid), 32'd0);
    chk("wr_waddr",  32'(imem_addr),   32'd0);
    step();
    chk_instr("wr", 16'h8000, 16'h0007, 16'hFFFF);
    chk("wr_naddr", 32'(imem_addr), 32'd1);

    // Asynchronous reset mid-cycle during S_IMM.
    branch_taken = 1'b1; branch_target = 16'h0050;
    step();
    branch_taken = 1'b0;
    step();
    chk_instr("ar_pre", 16'h0100, 16'h0000, 16'h0050);
    step();
    chk("ar_simm", 32'(imem_addr), 32'h0052);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(if_id_valid), 32'd0);
    chk("ar_instr", 32'(if_id_instr), 32'd0);
    chk("ar_imm",   32'(if_id_imm),   32'd0);
    chk("ar_pc",    32'(if_id_pc),    32'd0);
    chk("ar_addr",  32'(imem_addr),   32'd0);
    step();
    reset = 1'b0;
    chk("ar_raddr",  32'(imem_addr),   32'd0);
    chk("ar_rvalid", 32'(if_id_valid), 32'd0);
    step();
    chk_instr("ar_first", 16'h0007, 16'h0000, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
